// File: rtl/rom_ctrl_if.sv
// rtl/rom_ctrl_if.sv - request/response bus between a read master and rom_ctrl
//
// Purpose: bundles the byte-addressed request channel and the read response
// channel. Both channels use valid/ready handshakes.
// Signals:
//   req_valid / req_ready / req_addr        request channel, master -> slave
//   rsp_valid / rsp_ready / rsp_rdata / rsp_err  response channel, slave -> master
// Modports: master (issues requests, consumes responses), slave (rom_ctrl).

interface rom_ctrl_if #(
   parameter int BUS_AW     = 32,
   parameter int DATA_WIDTH = 32
);
   logic                  req_valid;
   logic                  req_ready;
   logic [BUS_AW-1:0]     req_addr;
   logic                  rsp_valid;
   logic                  rsp_ready;
   logic [DATA_WIDTH-1:0] rsp_rdata;
   logic                  rsp_err;

   modport master (
      output req_valid, req_addr, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_err
   );

   modport slave (
      input  req_valid, req_addr, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_err
   );
endinterface

// File: rtl/rom_ctrl.sv
// rtl/rom_ctrl.sv - bus front end for a synchronous single-port ROM
//
// Purpose: accepts byte-addressed read requests, converts them to ROM word
// addresses, tracks the ROM's one-cycle read latency and returns data through
// a 2-entry response buffer so backpressure never loses ROM data. Misaligned
// and out-of-range requests return rdata=0 with err=1, in request order.
// Ports:
//   clk_i        clock
//   rst_ni       synchronous active-low reset
//   bus          rom_ctrl_if slave: request and response channels
//   rom_addr_o   word address to the ROM, combinational from bus.req_addr
//   rom_rdata_i  ROM read data, valid one cycle after the address is sampled

module rom_ctrl #(
   parameter int                ADDR_WIDTH = 16,
   parameter int                DATA_WIDTH = 32,
   parameter longint unsigned   MEM_DEPTH  = 64'd1 << ADDR_WIDTH,
   parameter int                BUS_AW     = 32,
   parameter logic [BUS_AW-1:0] BASE_ADDR  = '0
) (
   input  logic                  clk_i,
   input  logic                  rst_ni,
   rom_ctrl_if.slave             bus,
   output logic [ADDR_WIDTH-1:0] rom_addr_o,
   input  logic [DATA_WIDTH-1:0] rom_rdata_i
);

   logic [BUS_AW-1:0]     off;
   logic [BUS_AW-1:0]     word_idx;
   logic                  req_err;
   logic                  accept;
   logic                  push;
   logic                  pop;
   logic [1:0]            level;
   logic [DATA_WIDTH-1:0] push_data;

   // Request in flight to the ROM (accepted last cycle) and its error flag.
   logic                  inflight;
   logic                  infl_err;

   // Two-entry response buffer: head drives the response outputs directly,
   // tail holds the second entry.
   logic                  head_valid;
   logic [DATA_WIDTH-1:0] head_data;
   logic                  head_err;
   logic                  tail_valid;
   logic [DATA_WIDTH-1:0] tail_data;
   logic                  tail_err;

   assign off        = bus.req_addr - BASE_ADDR;
   assign word_idx   = off >> 2;
   assign rom_addr_o = off[ADDR_WIDTH+1:2];

   assign req_err = (bus.req_addr[1:0] != 2'b00)
                 || (bus.req_addr < BASE_ADDR)
                 || (64'(word_idx) >= MEM_DEPTH);

   assign pop  = head_valid && bus.rsp_ready;
   assign push = inflight;

   // Slots committed after this cycle; pop implies head_valid so this
   // cannot underflow. Accept only while a slot remains for the new request.
   assign level         = 2'(head_valid) + 2'(tail_valid) + 2'(inflight) - 2'(pop);
   assign bus.req_ready = (level < 2'd2);
   assign accept        = bus.req_valid && bus.req_ready;

   assign push_data = infl_err ? '0 : rom_rdata_i;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         inflight   <= 1'b0;
         infl_err   <= 1'b0;
         head_valid <= 1'b0;
         head_data  <= '0;
         head_err   <= 1'b0;
         tail_valid <= 1'b0;
         tail_data  <= '0;
         tail_err   <= 1'b0;
      end else begin
         inflight <= accept;
         if (accept) begin
            infl_err <= req_err;
         end

         if (pop) begin
            if (tail_valid) begin
               head_data <= tail_data;
               head_err  <= tail_err;
               if (push) begin
                  tail_data <= push_data;
                  tail_err  <= infl_err;
               end else begin
                  tail_valid <= 1'b0;
               end
            end else if (push) begin
               head_data <= push_data;
               head_err  <= infl_err;
            end else begin
               // Data/err deliberately left holding the popped value.
               head_valid <= 1'b0;
            end
         end else if (push) begin
            if (!head_valid) begin
               head_valid <= 1'b1;
               head_data  <= push_data;
               head_err   <= infl_err;
            end else begin
               tail_valid <= 1'b1;
               tail_data  <= push_data;
               tail_err   <= infl_err;
            end
         end
      end
   end

   assign bus.rsp_valid = head_valid;
   assign bus.rsp_rdata = head_data;
   assign bus.rsp_err   = head_err;

endmodule
